// File: rtl/ex_issue_buf_pkg.sv
// Shared widths and bundle bit offsets for the ID->EX issue bundle.
// Fields are packed MSB-first: {aluOp, wdtOp, sigOp, imm, rdata1, rdata2, pc, inst, flush, rd}.
package ex_issue_buf_pkg;

  localparam int AluopWidth = 8;
  localparam int WdtTypeCnt = 4;
  localparam int SigOpWidth = 2;
  localparam int ImmWidth   = 64;
  localparam int InstWidth  = 32;
  localparam int RegIdWidth = 5;

  localparam int IB_RD_LSB     = 0;
  localparam int IB_FLUSH_LSB  = IB_RD_LSB + RegIdWidth;
  localparam int IB_INST_LSB   = IB_FLUSH_LSB + 1;
  localparam int IB_PC_LSB     = IB_INST_LSB + InstWidth;
  localparam int IB_RDATA2_LSB = IB_PC_LSB + ImmWidth;
  localparam int IB_RDATA1_LSB = IB_RDATA2_LSB + ImmWidth;
  localparam int IB_IMM_LSB    = IB_RDATA1_LSB + ImmWidth;
  localparam int IB_SIG_LSB    = IB_IMM_LSB + ImmWidth;
  localparam int IB_WDT_LSB    = IB_SIG_LSB + SigOpWidth;
  localparam int IB_ALUOP_LSB  = IB_WDT_LSB + WdtTypeCnt;
  localparam int IB_W          = IB_ALUOP_LSB + AluopWidth;

  function automatic int bundleWidth(input int aluopW, input int wdtW, input int sigW,
                                     input int dataW, input int instW, input int ridW);
    return aluopW + wdtW + sigW + 4 * dataW + instW + 1 + ridW;
  endfunction

endpackage

// File: rtl/ex_issue_buf_skid.sv
// pipe_skid_buf: small FIFO with registered ready, a kill that empties it, and zeroed payload on reset.
module pipe_skid_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pushValid,
  output logic             pushReady,
  input  logic [WIDTH-1:0] pushData,
  input  logic             kill,
  output logic             popValid,
  input  logic             popReady,
  output logic [WIDTH-1:0] popData
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count, countNext;
  logic             readyQ;
  logic             push, pop;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign push      = pushValid && readyQ;
  assign pop       = (count != '0) && popReady;
  assign pushReady = readyQ;
  assign popValid  = (count != '0);
  assign popData   = mem[head];

  always_comb begin
    countNext = count;
    if (kill)             countNext = '0;
    else if (push && !pop) countNext = count + 1'b1;
    else if (pop && !push) countNext = count - 1'b1;
  end

  // Ready is registered from the next occupancy so ID never sees a combinational path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      readyQ <= 1'b1;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      count  <= countNext;
      readyQ <= (countNext < CNT_W'(DEPTH));
      if (kill) begin
        head <= '0;
        tail <= '0;
      end else begin
        if (push) begin
          mem[tail] <= pushData;
          tail      <= nextPtr(tail);
        end
        if (pop) head <= nextPtr(head);
      end
    end
  end

endmodule

// File: rtl/ex_issue_buf.sv
// EX-side receiver for ID->EX bundles: two-entry skid buffer in front of the ALU
// plus a saturating counter of back-pressure cycles.
module ex_issue_buf
  import ex_issue_buf_pkg::*;
#(
  parameter int ALUOP_W = AluopWidth,
  parameter int WDT_W   = WdtTypeCnt,
  parameter int SIG_W   = SigOpWidth,
  parameter int DATA_W  = ImmWidth,
  parameter int INST_W  = InstWidth,
  parameter int RID_W   = RegIdWidth,
  parameter int CNT_W   = 32,
  localparam int B      = bundleWidth(ALUOP_W, WDT_W, SIG_W, DATA_W, INST_W, RID_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [B-1:0]     in_bundle,
  input  logic             kill,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [B-1:0]     out_bundle,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [CNT_W-1:0] stallCnt;

  pipe_skid_buf #(.WIDTH(B), .DEPTH(2)) uSkid (
    .clk      (clk),
    .rst      (rst),
    .pushValid(in_valid),
    .pushReady(in_ready),
    .pushData (in_bundle),
    .kill     (kill),
    .popValid (out_valid),
    .popReady (out_ready),
    .popData  (out_bundle)
  );

  // Kill does not touch the counter; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stallCnt <= '0;
    else if (out_valid && !out_ready && (stallCnt != '1)) stallCnt <= stallCnt + 1'b1;
  end

  assign stall_cnt = stallCnt;

endmodule

// File: tb/tb_ex_issue_buf.sv
// Directed bench for ex_issue_buf; a second instance with a 4-bit stall counter shares the stimulus.
module tb_ex_issue_buf;
  import ex_issue_buf_pkg::*;

  logic            clk, rst, in_valid, kill, out_ready;
  logic [IB_W-1:0] in_bundle;
  logic            in_ready, out_valid, in_ready4, out_valid4;
  logic [IB_W-1:0] out_bundle, out_bundle4;
  logic [31:0]     stall_cnt;
  logic [3:0]      stall_cnt4;

  int checks = 0;
  int errors = 0;

  ex_issue_buf dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_bundle(in_bundle),
    .kill(kill), .out_valid(out_valid), .out_ready(out_ready), .out_bundle(out_bundle),
    .stall_cnt(stall_cnt)
  );

  ex_issue_buf #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .in_bundle(in_bundle),
    .kill(kill), .out_valid(out_valid4), .out_ready(out_ready), .out_bundle(out_bundle4),
    .stall_cnt(stall_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [IB_W-1:0] mkB(input int n);
    logic [IB_W-1:0] b;
    b = '0;
    b[IB_ALUOP_LSB +: AluopWidth] = AluopWidth'(n + 3);
    b[IB_WDT_LSB +: WdtTypeCnt]   = WdtTypeCnt'(1 << (n % 4));
    b[IB_SIG_LSB +: SigOpWidth]   = SigOpWidth'(n);
    b[IB_IMM_LSB +: ImmWidth]     = {32'hA5A5_0000, 32'(n)};
    b[IB_RDATA1_LSB +: ImmWidth]  = {32'h1111_0000, 32'(n * 7)};
    b[IB_RDATA2_LSB +: ImmWidth]  = {32'h2222_0000, 32'(n * 13)};
    b[IB_PC_LSB +: ImmWidth]      = 64'h8000_0000 + 64'(4 * n);
    b[IB_INST_LSB +: InstWidth]   = 32'h0000_0013 + 32'(n << 7);
    b[IB_FLUSH_LSB]               = n[0];
    b[IB_RD_LSB +: RegIdWidth]    = RegIdWidth'(n + 1);
    return b;
  endfunction

  task automatic check(input string tag, input logic [IB_W-1:0] obs, input logic [IB_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; kill = 1'b0; out_ready = 1'b0; in_bundle = '0;

    // 1. asynchronous reset before any clock edge
    #3 rst = 1'b1;
    #1;
    check("rst_in_ready", IB_W'(in_ready), IB_W'(1));
    check("rst_out_valid", IB_W'(out_valid), IB_W'(0));
    check("rst_out_bundle", out_bundle, '0);
    check("rst_stall_cnt", IB_W'(stall_cnt), '0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // 2. flow-through
    out_ready = 1'b1; in_valid = 1'b1; in_bundle = mkB(0);
    tick();
    check("ft_v0", IB_W'(out_valid), IB_W'(1));
    check("ft_b0", out_bundle, mkB(0));
    check("ft_r0", IB_W'(in_ready), IB_W'(1));
    in_bundle = mkB(1);
    tick();
    check("ft_b1", out_bundle, mkB(1));
    check("ft_r1", IB_W'(in_ready), IB_W'(1));
    in_valid = 1'b0;
    tick();
    check("ft_empty", IB_W'(out_valid), IB_W'(0));
    check("ft_stall", IB_W'(stall_cnt), '0);

    // 3. back-pressure: A=10, B=11, C=12
    out_ready = 1'b0; in_valid = 1'b1; in_bundle = mkB(10);
    tick();
    check("bp_a_out", out_bundle, mkB(10));
    check("bp_a_rdy", IB_W'(in_ready), IB_W'(1));
    check("bp_stall0", IB_W'(stall_cnt), '0);
    in_bundle = mkB(11);
    tick();
    check("bp_full_rdy", IB_W'(in_ready), IB_W'(0));
    check("bp_hold_a", out_bundle, mkB(10));
    check("bp_stall1", IB_W'(stall_cnt), IB_W'(1));
    in_bundle = mkB(12);
    tick();
    check("bp_hold_a2", out_bundle, mkB(10));
    check("bp_stall2", IB_W'(stall_cnt), IB_W'(2));
    tick();
    check("bp_hold_a3", out_bundle, mkB(10));
    check("bp_rdy_low", IB_W'(in_ready), IB_W'(0));
    check("bp_stall3", IB_W'(stall_cnt), IB_W'(3));
    out_ready = 1'b1;
    tick();
    check("bp_b_out", out_bundle, mkB(11));
    check("bp_rdy_back", IB_W'(in_ready), IB_W'(1));
    tick();
    check("bp_c_out", out_bundle, mkB(12));
    check("bp_c_valid", IB_W'(out_valid), IB_W'(1));
    in_valid = 1'b0;
    tick();
    check("bp_empty", IB_W'(out_valid), IB_W'(0));
    check("bp_stall_final", IB_W'(stall_cnt), IB_W'(3));
    check("bp_stall4_final", IB_W'(stall_cnt4), IB_W'(3));

    // 4. kill with full buffer and concurrent push D=21; then E=22
    out_ready = 1'b0; in_valid = 1'b1; in_bundle = mkB(18);
    tick();
    in_bundle = mkB(19);
    tick();
    check("kl_full", IB_W'(in_ready), IB_W'(0));
    kill = 1'b1; in_bundle = mkB(21); out_ready = 1'b1;
    tick();
    check("kl_valid", IB_W'(out_valid), IB_W'(0));
    check("kl_rdy", IB_W'(in_ready), IB_W'(1));
    kill = 1'b0; in_valid = 1'b0;
    tick();
    check("kl_no_d", IB_W'(out_valid), IB_W'(0));
    in_valid = 1'b1; in_bundle = mkB(22);
    tick();
    check("kl_e_out", out_bundle, mkB(22));
    check("kl_e_valid", IB_W'(out_valid), IB_W'(1));
    in_valid = 1'b0;
    tick();
    check("kl_e_alone", IB_W'(out_valid), IB_W'(0));
    check("kl_stall", IB_W'(stall_cnt), IB_W'(4));
    kill = 1'b1; in_valid = 1'b1; in_bundle = mkB(23);
    tick();
    kill = 1'b0; in_valid = 1'b0;
    tick();
    check("kl_empty_push", IB_W'(out_valid), IB_W'(0));

    // 6. simultaneous push+pop with count held at 1
    out_ready = 1'b1; in_valid = 1'b1; in_bundle = mkB(30);
    tick();
    check("pp_first", out_bundle, mkB(30));
    for (int i = 1; i <= 8; i++) begin
      in_bundle = mkB(30 + i);
      tick();
      check("pp_out", out_bundle, mkB(30 + i));
      check("pp_rdy", IB_W'(in_ready), IB_W'(1));
    end
    in_valid = 1'b0;
    tick();
    check("pp_empty", IB_W'(out_valid), IB_W'(0));
    check("pp_stall", IB_W'(stall_cnt), IB_W'(4));

    // 1b. reset asserted mid-operation
    out_ready = 1'b0; in_valid = 1'b1; in_bundle = mkB(40);
    tick();
    in_valid = 1'b0;
    tick();
    check("mr_pre_stall", IB_W'(stall_cnt), IB_W'(5));
    #2 rst = 1'b1;
    #1;
    check("mr_in_ready", IB_W'(in_ready), IB_W'(1));
    check("mr_out_valid", IB_W'(out_valid), IB_W'(0));
    check("mr_out_bundle", out_bundle, '0);
    check("mr_stall", IB_W'(stall_cnt), '0);
    check("mr_stall4", IB_W'(stall_cnt4), '0);
    tick();
    rst = 1'b0;
    tick();

    // 5. saturation on the 4-bit counter instance
    in_valid = 1'b1; in_bundle = mkB(50);
    tick();
    in_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 15) check("sat_at15", IB_W'(stall_cnt4), IB_W'(15));
    end
    check("sat_hold", IB_W'(stall_cnt4), IB_W'(15));
    check("sat_wide", IB_W'(stall_cnt), IB_W'(20));
    check("sat_stable", out_bundle4, mkB(50));
    kill = 1'b1;
    tick();
    kill = 1'b0;
    tick();
    check("sat_after_kill", IB_W'(stall_cnt4), IB_W'(15));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
